// File: rtl/halt_result_monitor.sv
// halt_result_monitor: snoops the register-file write port of the RISC core,
// detects program termination (HALT_VAL written to HALT_REG), shadows the
// return-value register, counts run cycles and raises a watchdog timeout.
// Optional feature macro: HALT_MON_TRACE_EN enables the RF write counter
// (wr_count); without it wr_count is tied to zero.
module halt_result_monitor #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned ADDR_W     = 5,
  parameter int unsigned HALT_REG   = 1,
  parameter int unsigned HALT_VAL   = 1,
  parameter int unsigned RESULT_REG = 2,
  parameter int unsigned CYC_W      = 16,
  parameter int unsigned TIMEOUT    = 500
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic              i_clear,
  input  logic              i_rf_we,
  input  logic [ADDR_W-1:0] i_rf_waddr,
  input  logic [DATA_W-1:0] i_rf_wdata,
  output logic              o_running,
  output logic              o_done,
  output logic              o_timed_out,
  output logic [DATA_W-1:0] o_result,
  output logic [CYC_W-1:0]  o_cycles,
  output logic [CYC_W-1:0]  o_wr_count
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUN     = 2'd1,
    S_HALTED  = 2'd2,
    S_TIMEOUT = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_running;
  logic                r_done;
  logic                r_timed_out;
  logic [DATA_W-1:0]   r_result;
  logic [DATA_W-1:0]   w_result_nxt;
  logic [CYC_W-1:0]    r_cycles;
  logic [CYC_W-1:0]    w_cycles_nxt;

  logic                w_wr_nz;
  logic                w_res_wr;
  logic                w_halt_wr;
  logic                w_at_limit;

  // Write-port decode; address 0 is never a real write.
  always_comb begin
    w_wr_nz    = i_rf_we && (i_rf_waddr != '0);
    w_res_wr   = w_wr_nz && (i_rf_waddr == ADDR_W'(RESULT_REG));
    w_halt_wr  = w_wr_nz && (i_rf_waddr == ADDR_W'(HALT_REG))
                         && (i_rf_wdata == DATA_W'(HALT_VAL));
    w_at_limit = (r_cycles == CYC_W'(TIMEOUT - 1));
  end

  // Next state plus next result/cycle values; clear overrides everything.
  always_comb begin
    w_state_nxt  = r_state;
    w_result_nxt = r_result;
    w_cycles_nxt = r_cycles;
    if (i_clear) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_res_wr) w_result_nxt = i_rf_wdata;
          if (i_start) begin
            w_state_nxt  = S_RUN;
            w_cycles_nxt = '0;
            if (!w_res_wr) w_result_nxt = '0;
          end
        end
        S_RUN: begin
          if (r_cycles != '1) w_cycles_nxt = r_cycles + CYC_W'(1);
          if (w_res_wr) w_result_nxt = i_rf_wdata;
          // Halt wins over a coincident watchdog expiry.
          if (w_halt_wr)       w_state_nxt = S_HALTED;
          else if (w_at_limit) w_state_nxt = S_TIMEOUT;
        end
        default: ;
      endcase
    end
  end

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Registered status flags, result shadow and cycle counter.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_running   <= 1'b0;
      r_done      <= 1'b0;
      r_timed_out <= 1'b0;
      r_result    <= '0;
      r_cycles    <= '0;
    end else begin
      r_running   <= (w_state_nxt == S_RUN);
      r_done      <= (w_state_nxt == S_HALTED);
      r_timed_out <= (w_state_nxt == S_TIMEOUT);
      r_result    <= w_result_nxt;
      r_cycles    <= w_cycles_nxt;
    end
  end

`ifdef HALT_MON_TRACE_EN
  logic [CYC_W-1:0] r_wr_count;
  logic [CYC_W-1:0] w_wr_count_nxt;

  // Count non-zero-address writes while running, saturating.
  always_comb begin
    w_wr_count_nxt = r_wr_count;
    if (!i_clear) begin
      if (r_state == S_IDLE && i_start) begin
        w_wr_count_nxt = '0;
      end else if (r_state == S_RUN && w_wr_nz && r_wr_count != '1) begin
        w_wr_count_nxt = r_wr_count + CYC_W'(1);
      end
    end
  end

  // Write counter register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_wr_count <= '0;
    else          r_wr_count <= w_wr_count_nxt;
  end

  assign o_wr_count = r_wr_count;
`else
  assign o_wr_count = '0;
`endif

  assign o_running   = r_running;
  assign o_done      = r_done;
  assign o_timed_out = r_timed_out;
  assign o_result    = r_result;
  assign o_cycles    = r_cycles;

endmodule

// File: tb/tb_halt_result_monitor.sv
// tb_halt_result_monitor: directed prelude plus randomized RF traffic; a
// behavioural model predicts the outputs after every edge into a queue and a
// separate monitor compares them against the DUT.
module tb_halt_result_monitor;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned ADDR_W  = 5;
  localparam int unsigned CYC_W   = 16;
  localparam int unsigned TIMEOUT = 20;

  typedef struct packed {
    logic              running;
    logic              done;
    logic              timed_out;
    logic [DATA_W-1:0] result;
    logic [CYC_W-1:0]  cycles;
    logic [CYC_W-1:0]  wr_count;
  } obs_t;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic              clear;
  logic              rf_we;
  logic [ADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic              running;
  logic              done;
  logic              timed_out;
  logic [DATA_W-1:0] result;
  logic [CYC_W-1:0]  cycles;
  logic [CYC_W-1:0]  wr_count;

  halt_result_monitor #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .HALT_REG(1), .HALT_VAL(1),
    .RESULT_REG(2), .CYC_W(CYC_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_clear(clear),
    .i_rf_we(rf_we), .i_rf_waddr(rf_waddr), .i_rf_wdata(rf_wdata),
    .o_running(running), .o_done(done), .o_timed_out(timed_out),
    .o_result(result), .o_cycles(cycles), .o_wr_count(wr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  obs_t exp_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;
  int   n_halt = 0;
  int   n_tmo  = 0;

  // Reference model: phase 0=idle 1=run 2=halted 3=timeout.
  int                m_phase;
  logic [DATA_W-1:0] m_result;
  int unsigned       m_cyc;
  int unsigned       m_wr;

  function automatic int unsigned sat_inc(input int unsigned v);
    return (v >= 32'((1 << CYC_W) - 1)) ? v : v + 1;
  endfunction

  task automatic model_step(input logic r, input logic st, input logic cl,
                            input logic we, input logic [ADDR_W-1:0] a,
                            input logic [DATA_W-1:0] d);
    bit real_wr;
    bit is_res;
    bit is_halt;
    int unsigned old_cyc;
    real_wr = we && (a != 0);
    is_res  = real_wr && (a == 2);
    is_halt = real_wr && (a == 1) && (d == 1);
    if (!r) begin
      m_phase = 0; m_result = '0; m_cyc = 0; m_wr = 0;
    end else if (cl) begin
      m_phase = 0;
    end else if (m_phase == 0) begin
      if (is_res) m_result = d;
      if (st) begin
        m_phase = 1; m_cyc = 0; m_wr = 0;
        if (!is_res) m_result = '0;
      end
    end else if (m_phase == 1) begin
      old_cyc = m_cyc;
      m_cyc   = sat_inc(m_cyc);
      if (real_wr) m_wr = sat_inc(m_wr);
      if (is_res) m_result = d;
      if (is_halt) begin
        m_phase = 2; n_halt++;
      end else if (old_cyc == TIMEOUT - 1) begin
        m_phase = 3; n_tmo++;
      end
    end
  endtask

  function automatic obs_t model_obs();
    obs_t o;
    o.running   = (m_phase == 1);
    o.done      = (m_phase == 2);
    o.timed_out = (m_phase == 3);
    o.result    = m_result;
    o.cycles    = CYC_W'(m_cyc);
`ifdef HALT_MON_TRACE_EN
    o.wr_count  = CYC_W'(m_wr);
`else
    o.wr_count  = '0;
`endif
    return o;
  endfunction

  // Drive one cycle of stimulus and queue the predicted post-edge outputs.
  task automatic step(input logic r, input logic st, input logic cl,
                      input logic we, input logic [ADDR_W-1:0] a,
                      input logic [DATA_W-1:0] d);
    @(negedge clk);
    rst_n = r; start = st; clear = cl; rf_we = we; rf_waddr = a; rf_wdata = d;
    model_step(r, st, cl, we, a, d);
    exp_q.push_back(model_obs());
  endtask

  task automatic idle_cyc(input int n);
    for (int k = 0; k < n; k++) step(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    step(1'b1, 1'b0, 1'b0, 1'b1, a, d);
  endtask

  // Monitor: compare the DUT against the oldest prediction after each edge.
  initial begin
    obs_t e;
    obs_t g;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        g = '{running, done, timed_out, result, cycles, wr_count};
        n_cmp++;
        if (g !== e) begin
          n_fail++;
          $display("FAIL outputs t=%0t got run=%b done=%b tmo=%b res=%h cyc=%0d wr=%0d exp run=%b done=%b tmo=%b res=%h cyc=%0d wr=%0d",
                   $time, g.running, g.done, g.timed_out, g.result, g.cycles, g.wr_count,
                   e.running, e.done, e.timed_out, e.result, e.cycles, e.wr_count);
        end
      end
    end
  end

  initial begin
    logic              r_st;
    logic              r_cl;
    logic              r_we;
    logic              r_rs;
    logic [ADDR_W-1:0] r_a;
    logic [DATA_W-1:0] r_d;
    rst_n = 1'b0; start = 1'b0; clear = 1'b0;
    rf_we = 1'b0; rf_waddr = '0; rf_wdata = '0;
    m_phase = 0; m_result = '0; m_cyc = 0; m_wr = 0;

    // Reset held for two cycles.
    step(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    step(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);

    // Normal halt: r2=42 then r1=1; an r0 write is ignored.
    step(1'b1, 1'b1, 1'b0, 1'b0, '0, '0);
    idle_cyc(3); wr(5'd2, 32'd42); wr(5'd0, 32'd1); idle_cyc(1);
    wr(5'd1, 32'd1); idle_cyc(3);

    // Clear back to idle; pre-start capture; false halt then real halt.
    step(1'b1, 1'b0, 1'b1, 1'b0, '0, '0);
    wr(5'd2, 32'hDEAD_BEEF);
    step(1'b1, 1'b1, 1'b0, 1'b1, 5'd2, 32'h1234_5678);
    wr(5'd1, 32'd5); idle_cyc(2); wr(5'd1, 32'd1); idle_cyc(2);

    // Timeout, then a late halt write and a late start are ignored.
    step(1'b1, 1'b0, 1'b1, 1'b0, '0, '0);
    step(1'b1, 1'b1, 1'b0, 1'b0, '0, '0);
    idle_cyc(TIMEOUT + 2); wr(5'd1, 32'd1);
    step(1'b1, 1'b1, 1'b0, 1'b0, '0, '0);

    // Halt write on the exact timeout cycle: halt wins.
    step(1'b1, 1'b0, 1'b1, 1'b0, '0, '0);
    step(1'b1, 1'b1, 1'b0, 1'b0, '0, '0);
    idle_cyc(TIMEOUT - 1); wr(5'd1, 32'd1); idle_cyc(2);

    // clear+start together stays idle; then abort a run with reset.
    step(1'b1, 1'b1, 1'b1, 1'b0, '0, '0);
    step(1'b1, 1'b1, 1'b0, 1'b0, '0, '0);
    wr(5'd2, 32'd7); idle_cyc(2);
    step(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    idle_cyc(2);

    // Randomized traffic.
    for (int i = 0; i < 4000; i++) begin
      r_rs = ($urandom_range(0, 299) != 0);
      r_st = ($urandom_range(0, 3) == 0);
      r_cl = ($urandom_range(0, 24) == 0);
      r_we = ($urandom_range(0, 2) == 0);
      r_a  = ($urandom_range(0, 3) != 0) ? ADDR_W'($urandom_range(0, 3))
                                         : ADDR_W'($urandom_range(0, 31));
      if (r_a == 5'd1 && $urandom_range(0, 1) == 0) r_d = 32'd1;
      else if ($urandom_range(0, 1) == 0)           r_d = 32'($urandom_range(0, 7));
      else                                          r_d = $urandom;
      step(r_rs, r_st, r_cl, r_we, r_a, r_d);
    end

    // Every prediction must have been consumed by the monitor.
    idle_cyc(1);
    repeat (3) @(negedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    $display("halts=%0d timeouts=%0d", n_halt, n_tmo);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
